game_sequencer: RTL and testbench

- Round-level controller for the cannon game. Sits between the controls block and the trajectory calculator, and downstream of the trajectory calculator's result outputs.
- Sequences each shot: show target X, show target Y, let the player aim, gate one shot, wait for the result, then score it.
- Tracks shots remaining and score, and drives the 5-bit one-hot display select toward the output mux.

---
 rtl/game_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Purpose: round-level controller for the cannon game (target show, aim, shoot, score).
// Latency: start edge -> SHOW_X next cycle; shoot_req -> shoot_out one cycle later.
// Backpressure: none; shoot_req is dropped outside PLAY, result_valid outside FLIGHT.
module game_sequencer #(
  parameter int SHOTS_PER_ROUND = 5,
  parameter int SHOW_CYCLES     = 16,
  parameter int FLIGHT_TIMEOUT  = 255,
  parameter int SCORE_W         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_new_game,
  input  logic               shoot_req,
  input  logic [4:0]         select_in,
  input  logic               result_valid,
  input  logic               hit,
  output logic               shoot_out,
  output logic [4:0]         select_out,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         shots_left,
  output logic               game_over,
  output logic               in_flight
);

  // One shared timer serves both the show phases and the flight timeout,
  // so it is sized for whichever of the two runs longer.
  localparam int MAX_CYCLES = (SHOW_CYCLES > FLIGHT_TIMEOUT) ? SHOW_CYCLES : FLIGHT_TIMEOUT;
  localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SHOW_X = 3'd1;
  localparam logic [2:0] SHOW_Y = 3'd2;
  localparam logic [2:0] PLAY   = 3'd3;
  localparam logic [2:0] FLIGHT = 3'd4;
  localparam logic [2:0] OVER   = 3'd5;

  localparam logic [4:0] SEL_X      = 5'b00100;
  localparam logic [4:0] SEL_Y      = 5'b00010;
  localparam logic [4:0] SEL_FLIGHT = 5'b00001;

  localparam logic [TIMER_W-1:0] SHOW_LAST   = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FLIGHT_LAST = TIMER_W'(FLIGHT_TIMEOUT - 1);

  logic [2:0]         r_state;
  logic [TIMER_W-1:0] r_timer;
  logic               r_start_q;
  logic               r_shoot_out;
  logic [SCORE_W-1:0] r_score;
  logic [3:0]         r_shots_left;
  logic               r_game_over;
  logic               r_in_flight;

  logic [2:0]         w_state_nxt;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic               w_start_edge;
  logic               w_show_done;
  logic               w_flight_to;
  logic               w_fire;
  logic               w_result;
  logic               w_flight_end;
  logic [2:0]         w_after_shot;

  assign w_start_edge = start_new_game & ~r_start_q;
  assign w_show_done  = (r_timer == SHOW_LAST);
  assign w_flight_to  = (r_timer == FLIGHT_LAST);
  assign w_fire       = (r_state == PLAY) && shoot_req && (r_shots_left != 4'd0);
  assign w_result     = (r_state == FLIGHT) && result_valid;
  // A result arriving in the timeout cycle still ends the flight as a real result.
  assign w_flight_end = (r_state == FLIGHT) && (result_valid || w_flight_to);
  // shots_left was already decremented when the shot fired, so zero here means last shot.
  assign w_after_shot = (r_shots_left == 4'd0) ? OVER : SHOW_X;

  // Register the start level so only a fresh rising edge starts a game.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= start_new_game;
    end
  end

  // Next-state selection; a start edge overrides every other event.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start_edge) begin
      w_state_nxt = SHOW_X;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        SHOW_X:  if (w_show_done) w_state_nxt = SHOW_Y;
        SHOW_Y:  if (w_show_done) w_state_nxt = PLAY;
        PLAY:    if (w_fire) w_state_nxt = FLIGHT;
        FLIGHT:  if (w_flight_end) w_state_nxt = w_after_shot;
        OVER:    w_state_nxt = OVER;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Timer runs in the show and flight phases and clears on every phase change.
  always_comb begin
    w_timer_nxt = r_timer;
    if (w_start_edge) begin
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        SHOW_X, SHOW_Y: w_timer_nxt = w_show_done ? '0 : r_timer + 1'b1;
        FLIGHT:         w_timer_nxt = w_flight_end ? '0 : r_timer + 1'b1;
        PLAY:           w_timer_nxt = '0;
        default:        w_timer_nxt = '0;
      endcase
    end
  end

  // State and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Gated shoot pulse: exactly the PLAY->FLIGHT transition cycle, never on a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shoot_out <= 1'b0;
    end else begin
      r_shoot_out <= w_fire & ~w_start_edge;
    end
  end

  // Shot counter: reloaded on start, decremented as each shot leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shots_left <= 4'd0;
    end else if (w_start_edge) begin
      r_shots_left <= 4'(SHOTS_PER_ROUND);
    end else if (w_fire) begin
      r_shots_left <= r_shots_left - 4'd1;
    end
  end

  // Score counter: cleared on start, saturating increment on a reported hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score <= '0;
    end else if (w_start_edge) begin
      r_score <= '0;
    end else if (w_result && hit && (r_score != {SCORE_W{1'b1}})) begin
      r_score <= r_score + 1'b1;
    end
  end

  // Status flags registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_game_over <= 1'b0;
      r_in_flight <= 1'b0;
    end else begin
      r_game_over <= (w_state_nxt == OVER);
      r_in_flight <= (w_state_nxt == FLIGHT);
    end
  end

  // Display select: fixed codes while the block owns the display, else player pass-through.
  always_comb begin
    select_out = select_in;
    case (r_state)
      SHOW_X:  select_out = SEL_X;
      SHOW_Y:  select_out = SEL_Y;
      FLIGHT:  select_out = SEL_FLIGHT;
      default: select_out = select_in;
    endcase
  end

  assign shoot_out  = r_shoot_out;
  assign score      = r_score;
  assign shots_left = r_shots_left;
  assign game_over  = r_game_over;
  assign in_flight  = r_in_flight;

endmodule

// File: tb/tb_game_sequencer.sv
// Purpose: directed self-checking bench for game_sequencer.
// Latency: inputs driven 1 time unit after posedge, outputs checked at the same point.
// Backpressure: not applicable; all waits are fixed cycle counts.
module tb_game_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_new_game;
  logic       shoot_req;
  logic [4:0] select_in;
  logic       result_valid;
  logic       hit;
  logic       shoot_out;
  logic [4:0] select_out;
  logic [3:0] score;
  logic [3:0] shots_left;
  logic       game_over;
  logic       in_flight;

  int n_total = 0;
  int n_bad   = 0;

  game_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_new_game (start_new_game),
    .shoot_req      (shoot_req),
    .select_in      (select_in),
    .result_valid   (result_valid),
    .hit            (hit),
    .shoot_out      (shoot_out),
    .select_out     (select_out),
    .score          (score),
    .shots_left     (shots_left),
    .game_over      (game_over),
    .in_flight      (in_flight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk the remaining show cycles and confirm the block lands in PLAY.
  task automatic skip_show(input int n);
    repeat (n) tick();
    check_val("play_passthru", 32'(select_out), 32'(select_in));
  endtask

  // One shoot_req pulse from PLAY; checks the gated pulse and shot count.
  task automatic fire(input logic [3:0] left_after);
    shoot_req = 1'b1;
    tick();
    shoot_req = 1'b0;
    check_val("fire_shoot_out", 32'(shoot_out), 32'd1);
    check_val("fire_shots_left", 32'(shots_left), 32'(left_after));
  endtask

  task automatic result(input logic h);
    result_valid = 1'b1;
    hit = h;
    tick();
    result_valid = 1'b0;
    hit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_new_game = 1'b0;
    shoot_req = 1'b0;
    select_in = 5'b10000;
    result_valid = 1'b0;
    hit = 1'b0;
    #12;
    // Reset state
    check_val("rst_shots_left", 32'(shots_left), 32'd0);
    check_val("rst_score", 32'(score), 32'd0);
    check_val("rst_game_over", 32'(game_over), 32'd0);
    check_val("rst_in_flight", 32'(in_flight), 32'd0);
    check_val("rst_shoot_out", 32'(shoot_out), 32'd0);
    check_val("rst_select", 32'(select_out), 32'h10);
    rst_n = 1'b1;
    repeat (8) tick();
    // IDLE ignores shoot_req
    shoot_req = 1'b1;
    tick();
    shoot_req = 1'b0;
    check_val("idle_no_shoot", 32'(shoot_out), 32'd0);

    // Test 1: start held high, show X then Y, then PLAY
    start_new_game = 1'b1;
    select_in = 5'b01000;
    tick();
    for (int i = 0; i < 16; i++) check_val("show_x", 32'(select_out), 32'h04) ;
    for (int i = 0; i < 16; i++) begin
      check_val("show_x_cyc", 32'(select_out), 32'h04);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      check_val("show_y_cyc", 32'(select_out), 32'h02);
      tick();
    end
    check_val("play_sel", 32'(select_out), 32'h08);
    select_in = 5'b10101;
    #1;
    check_val("play_non_onehot", 32'(select_out), 32'h15);
    check_val("play_shots", 32'(shots_left), 32'd5);
    check_val("play_score", 32'(score), 32'd0);
    select_in = 5'b01000;

    // Test 2: shot 1, pulse is single-cycle, extra shoot_req ignored
    fire(4'd4);
    check_val("flight_in_flight", 32'(in_flight), 32'd1);
    check_val("flight_sel", 32'(select_out), 32'h01);
    tick();
    check_val("shoot_one_cycle", 32'(shoot_out), 32'd0);
    shoot_req = 1'b1;
    tick();
    shoot_req = 1'b0;
    check_val("flight_no_shoot", 32'(shoot_out), 32'd0);
    check_val("flight_shots_hold", 32'(shots_left), 32'd4);

    // Test 3: hit then miss
    result(1'b1);
    check_val("hit_score", 32'(score), 32'd1);
    check_val("hit_to_show_x", 32'(select_out), 32'h04);
    check_val("hit_not_flight", 32'(in_flight), 32'd0);
    skip_show(32);
    fire(4'd3);
    result(1'b0);
    check_val("miss_score", 32'(score), 32'd1);
    check_val("miss_to_show_x", 32'(select_out), 32'h04);

    // Test 4: timeout miss, then late result ignored in SHOW_X
    skip_show(32);
    fire(4'd2);
    repeat (254) tick();
    check_val("to_still_flight", 32'(in_flight), 32'd1);
    tick();
    check_val("to_left_flight", 32'(in_flight), 32'd0);
    check_val("to_sel_x", 32'(select_out), 32'h04);
    check_val("to_score", 32'(score), 32'd1);
    result(1'b1);
    check_val("late_result_ignored", 32'(score), 32'd1);

    // Result in the timeout cycle still counts
    skip_show(31);
    fire(4'd1);
    repeat (254) tick();
    result(1'b1);
    check_val("edge_result_score", 32'(score), 32'd2);
    check_val("edge_result_sel", 32'(select_out), 32'h04);

    // Test 5: last shot ends the game
    skip_show(32);
    fire(4'd0);
    result(1'b1);
    check_val("over_score", 32'(score), 32'd3);
    check_val("over_flag", 32'(game_over), 32'd1);
    check_val("over_shots", 32'(shots_left), 32'd0);
    check_val("over_sel", 32'(select_out), 32'h08);
    shoot_req = 1'b1;
    tick();
    shoot_req = 1'b0;
    check_val("over_no_shoot", 32'(shoot_out), 32'd0);
    check_val("over_stays", 32'(game_over), 32'd1);
    start_new_game = 1'b0;
    tick();
    start_new_game = 1'b1;
    tick();
    check_val("restart_score", 32'(score), 32'd0);
    check_val("restart_over", 32'(game_over), 32'd0);
    check_val("restart_shots", 32'(shots_left), 32'd5);
    check_val("restart_sel", 32'(select_out), 32'h04);

    // Test 6: start edge beats a hit in the same cycle
    skip_show(32);
    fire(4'd4);
    start_new_game = 1'b0;
    tick();
    start_new_game = 1'b1;
    result(1'b1);
    check_val("prio_score", 32'(score), 32'd0);
    check_val("prio_shots", 32'(shots_left), 32'd5);
    check_val("prio_sel", 32'(select_out), 32'h04);
    check_val("prio_no_flight", 32'(in_flight), 32'd0);

    // Asynchronous reset mid-flight while shoot_out is high
    skip_show(32);
    fire(4'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_shoot_out", 32'(shoot_out), 32'd0);
    check_val("arst_in_flight", 32'(in_flight), 32'd0);
    check_val("arst_shots", 32'(shots_left), 32'd0);
    check_val("arst_score", 32'(score), 32'd0);
    check_val("arst_sel_idle", 32'(select_out), 32'h08);
    start_new_game = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rst_idle", 32'(game_over), 32'd0);
    check_val("post_rst_shots", 32'(shots_left), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
